hazard_fwd_ctrl: RTL and testbench

Pipeline hazard controller for the ID→EX boundary of the 5-stage RV32I core. It sits beside the operand-select stage and tracks the destination registers of instructions in EX, MEM and WB. For each instruction issuing into EX it produces registered forwarding selects for operand1, operand2 and store data. It also inserts a one-cycle load-use bubble, and handles flush and downstream back-pressure.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/op_use_decode.sv | 49 ++++
 rtl/hazard_fwd_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared core definitions: opcode constants, forwarding select encoding,
// pipeline tracking entry and hazard FSM states.
package cpu_pkg;

    localparam int RF_AW = 5;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_IMM  = 7'b0010011;
    localparam logic [6:0] OP_I_LOAD = 7'b0000011;
    localparam logic [6:0] OP_S_TYPE = 7'b0100011;
    localparam logic [6:0] OP_B_TYPE = 7'b1100011;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic             valid;
        logic [RF_AW-1:0] rd;
        logic             wr;
        logic             load;
    } stage_entry_t;

    typedef enum logic {
        RUN = 1'b0,
        LU  = 1'b1
    } hz_state_t;

endpackage

// File: rtl/op_use_decode.sv
// Register-usage decode of an RV32I opcode: which sources are read, whether
// rd is written, and whether the instruction is a load or a store.
module op_use_decode
    import cpu_pkg::*;
(
    input  logic [6:0] op_i,
    output logic       reads_rs1_o,
    output logic       reads_rs2_o,
    output logic       writes_rd_o,
    output logic       is_load_o,
    output logic       is_store_o
);

    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        reads_rs1_o = 1'b0;
        reads_rs2_o = 1'b0;
        writes_rd_o = 1'b0;
        is_load_o   = 1'b0;
        is_store_o  = 1'b0;
        case (op_i)
            OP_R_TYPE: begin
                reads_rs1_o = 1'b1;
                reads_rs2_o = 1'b1;
                writes_rd_o = 1'b1;
            end
            OP_I_IMM: begin
                reads_rs1_o = 1'b1;
                writes_rd_o = 1'b1;
            end
            OP_I_LOAD: begin
                reads_rs1_o = 1'b1;
                writes_rd_o = 1'b1;
                is_load_o   = 1'b1;
            end
            OP_S_TYPE: begin
                reads_rs1_o = 1'b1;
                reads_rs2_o = 1'b1;
                is_store_o  = 1'b1;
            end
            OP_B_TYPE: begin
                reads_rs1_o = 1'b1;
                reads_rs2_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// ID->EX hazard controller: load-use bubble, flush, back-pressure and
// registered forwarding selects. HAZ_PERF_EN adds saturating perf counters.
module hazard_fwd_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_AW = 5
`ifdef HAZ_PERF_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [6:0]        id_op,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_ready,
    input  logic              flush,
    output logic              stall_id,
    output logic              issue,
    output logic              ex_bubble,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [1:0]        fwd_s
`ifdef HAZ_PERF_EN
    ,
    output logic [CNT_W-1:0]  lu_stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    stage_entry_t ex_q, mem_q, wb_q, ex_d, mem_d, wb_d, id_entry;
    hz_state_t    state_q, state_d;
    fwd_sel_t     fwd_a_q, fwd_b_q, fwd_s_q, fwd_a_d, fwd_b_d, fwd_s_d;

    logic reads_rs1, reads_rs2, writes_rd, is_load, is_store;
    logic raw_hazard, hazard, issue_int;

    op_use_decode u_dec (
        .op_i        (id_op),
        .reads_rs1_o (reads_rs1),
        .reads_rs2_o (reads_rs2),
        .writes_rd_o (writes_rd),
        .is_load_o   (is_load),
        .is_store_o  (is_store)
    );

    function automatic logic hit(input stage_entry_t e, input logic [REG_AW-1:0] rs);
        return e.valid && e.wr && (e.rd == rs);
    endfunction

    function automatic fwd_sel_t pick(input logic used, input logic [REG_AW-1:0] rs,
                                      input stage_entry_t ex, input stage_entry_t mem,
                                      input stage_entry_t wb);
        if (!used || rs == '0) return FWD_RF;
        if (hit(ex, rs))       return FWD_EXMEM;
        if (hit(mem, rs))      return FWD_MEMWB;
        // A WB writer lands in the regfile before the read, so it needs no bypass.
        if (hit(wb, rs))       return FWD_RF;
        return FWD_RF;
    endfunction

    assign id_entry = '{valid: 1'b1,
                        rd:    id_rd,
                        wr:    writes_rd && (id_rd != '0),
                        load:  is_load};

    assign raw_hazard = ex_q.valid && ex_q.load && ex_q.wr &&
                        ((reads_rs1 && id_rs1 == ex_q.rd) ||
                         (reads_rs2 && id_rs2 == ex_q.rd));

    always_comb begin
        state_d   = state_q;
        hazard    = 1'b0;
        issue_int = 1'b0;
        stall_id  = 1'b0;
        issue     = 1'b0;
        ex_bubble = 1'b0;
        case (state_q)
            RUN: begin
                hazard = id_valid && !flush && raw_hazard;
                if (hazard && ex_ready) state_d = LU;
            end
            LU: begin
                // The load has left EX, so only a new EX entry could conflict.
                if (flush || ex_ready) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        issue_int = id_valid && ex_ready && !flush && !hazard;
        issue     = rst_n && issue_int;
        stall_id  = rst_n && ((id_valid && !ex_ready) || hazard);
        ex_bubble = rst_n && ex_ready && !issue_int;
    end

    always_comb begin
        ex_d    = ex_q;
        mem_d   = mem_q;
        wb_d    = wb_q;
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        fwd_s_d = fwd_s_q;
        if (ex_ready) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            ex_d  = issue_int ? id_entry : '0;
            if (issue_int) begin
                fwd_a_d = pick(reads_rs1, id_rs1, ex_q, mem_q, wb_q);
                fwd_b_d = pick(reads_rs2 && !is_store, id_rs2, ex_q, mem_q, wb_q);
                fwd_s_d = pick(is_store, id_rs2, ex_q, mem_q, wb_q);
            end else begin
                fwd_a_d = FWD_RF;
                fwd_b_d = FWD_RF;
                fwd_s_d = FWD_RF;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
            fwd_s_q <= FWD_RF;
        end else begin
            // NOTE: state uses <= so every flop samples the pre-edge values.
            state_q <= state_d;
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            fwd_s_q <= fwd_s_d;
        end
    end

    assign fwd_a = fwd_a_q;
    assign fwd_b = fwd_b_q;
    assign fwd_s = fwd_s_q;

`ifdef HAZ_PERF_EN
    logic [CNT_W-1:0] lu_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_cnt_q    <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (hazard && ex_ready && lu_cnt_q != '1) lu_cnt_q <= lu_cnt_q + 1'b1;
            if (flush && id_valid && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign lu_stall_cnt = lu_cnt_q;
    assign flush_cnt    = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: directed vector table, reset corner sequences and
// randomized traffic against an in-flight-instruction reference model.
module tb_hazard_fwd_ctrl;

    localparam logic [6:0] OPR = 7'b0110011;
    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] OPL = 7'b0000011;
    localparam logic [6:0] OPS = 7'b0100011;
    localparam logic [6:0] OPB = 7'b1100011;
    localparam logic [6:0] OPX = 7'b0110111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [6:0] id_op = '0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       ex_ready = 1'b0;
    logic       flush = 1'b0;
    logic       stall_id, issue, ex_bubble;
    logic [1:0] fwd_a, fwd_b, fwd_s;
`ifdef HAZ_PERF_EN
    logic [31:0] lu_stall_cnt, flush_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_fwd_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .id_valid  (id_valid),
        .id_op     (id_op),
        .id_rs1    (id_rs1),
        .id_rs2    (id_rs2),
        .id_rd     (id_rd),
        .ex_ready  (ex_ready),
        .flush     (flush),
        .stall_id  (stall_id),
        .issue     (issue),
        .ex_bubble (ex_bubble),
        .fwd_a     (fwd_a),
        .fwd_b     (fwd_b),
        .fwd_s     (fwd_s)
`ifdef HAZ_PERF_EN
        ,
        .lu_stall_cnt (lu_stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    typedef struct {
        logic       v;
        logic [6:0] op;
        logic [4:0] rs1, rs2, rd;
        logic       rdy, fl;
        logic [2:0] ctl;   // {stall_id, issue, ex_bubble}
        logic [5:0] fwd;   // {fwd_a, fwd_b, fwd_s} of the previous slot
    } vec_t;

    typedef struct {
        logic       v, wr, ld;
        logic [4:0] rd;
    } slot_t;

    vec_t  tbl[26];
    slot_t pipe[3];        // [0] in EX, [1] in MEM, [2] in WB
    logic [5:0] m_fwd;

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int v, input logic [6:0] op, input int rs1, input int rs2,
                                input int rd, input int rdy, input int fl,
                                input logic [2:0] ctl, input logic [5:0] fwd);
        vec_t t;
        t.v = 1'(v); t.op = op; t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.rd = 5'(rd);
        t.rdy = 1'(rdy); t.fl = 1'(fl); t.ctl = ctl; t.fwd = fwd;
        return t;
    endfunction

    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic rdy,
                         input logic fl);
        id_valid = v; id_op = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        ex_ready = rdy; flush = fl;
    endtask

    function automatic logic [1:0] src(input logic used, input logic [4:0] rs);
        if (!used || rs == 5'd0) return 2'b00;
        for (int i = 0; i < 2; i++)
            if (pipe[i].v && pipe[i].wr && pipe[i].rd == rs) return (i == 0) ? 2'b01 : 2'b10;
        return 2'b00;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) pipe[i] = '{v: 1'b0, wr: 1'b0, ld: 1'b0, rd: 5'd0};
        m_fwd = '0;
    endtask

    initial begin
        logic [6:0] ops[6];
        ops = '{OPR, OPI, OPL, OPS, OPB, OPX};

        tbl[0]  = mk(1, OPR, 1, 2, 5, 1, 0, 3'b010, 6'b000000);   // add x5,x1,x2
        tbl[1]  = mk(1, OPR, 5, 3, 6, 1, 0, 3'b010, 6'b000000);   // sub x6,x5,x3
        tbl[2]  = mk(0, OPX, 0, 0, 0, 1, 0, 3'b001, 6'b010000);
        tbl[3]  = mk(1, OPI, 0, 0, 7, 1, 0, 3'b010, 6'b000000);   // addi x7,x0,1
        tbl[4]  = mk(1, OPI, 7, 0, 7, 1, 0, 3'b010, 6'b000000);   // addi x7,x7,1
        tbl[5]  = mk(1, OPR, 7, 7, 8, 1, 0, 3'b010, 6'b010000);   // add x8,x7,x7
        tbl[6]  = mk(1, OPR, 7, 0, 8, 1, 0, 3'b010, 6'b010100);   // add x8,x7,x0
        tbl[7]  = mk(0, OPX, 0, 0, 0, 1, 0, 3'b001, 6'b100000);
        tbl[8]  = mk(0, OPX, 0, 0, 0, 1, 0, 3'b001, 6'b000000);
        tbl[9]  = mk(1, OPL, 1, 0, 4, 1, 0, 3'b010, 6'b000000);   // lw x4,0(x1)
        tbl[10] = mk(1, OPS, 2, 4, 0, 1, 0, 3'b101, 6'b000000);   // sw x4,8(x2): stall
        tbl[11] = mk(1, OPS, 2, 4, 0, 1, 0, 3'b010, 6'b000000);   // sw issues
        tbl[12] = mk(0, OPX, 0, 0, 0, 1, 0, 3'b001, 6'b000010);   // fwd_s=10
        tbl[13] = mk(1, OPI, 1, 0, 0, 1, 0, 3'b010, 6'b000000);   // addi x0,x1,5
        tbl[14] = mk(1, OPR, 0, 0, 3, 1, 0, 3'b010, 6'b000000);   // add x3,x0,x0
        tbl[15] = mk(0, OPX, 0, 0, 0, 1, 0, 3'b001, 6'b000000);
        tbl[16] = mk(1, OPL, 1, 0, 10, 1, 0, 3'b010, 6'b000000);  // lw x10
        tbl[17] = mk(1, OPR, 10, 0, 11, 1, 1, 3'b001, 6'b000000); // hazard + flush
        tbl[18] = mk(1, OPR, 10, 0, 11, 1, 0, 3'b010, 6'b000000);
        tbl[19] = mk(0, OPX, 0, 0, 0, 1, 0, 3'b001, 6'b100000);
        tbl[20] = mk(1, OPR, 11, 11, 12, 1, 0, 3'b010, 6'b000000);
        tbl[21] = mk(1, OPR, 12, 1, 13, 0, 0, 3'b100, 6'b101000); // back-pressure
        tbl[22] = mk(1, OPR, 12, 1, 13, 0, 0, 3'b100, 6'b101000);
        tbl[23] = mk(1, OPR, 12, 1, 13, 0, 0, 3'b100, 6'b101000);
        tbl[24] = mk(1, OPR, 12, 1, 13, 1, 0, 3'b010, 6'b101000);
        tbl[25] = mk(0, OPX, 0, 0, 0, 1, 0, 3'b001, 6'b010000);

        // Outputs stay quiet in reset even with a valid instruction presented.
        drive(1'b1, OPR, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        #3;
        check("reset_ctl", 6'({stall_id, issue, ex_bubble}), 6'b000000);
        check("reset_fwd", {fwd_a, fwd_b, fwd_s}, 6'b000000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            drive(tbl[i].v, tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].rdy, tbl[i].fl);
            @(negedge clk);
            check($sformatf("vec%0d_ctl", i), 6'({stall_id, issue, ex_bubble}), 6'(tbl[i].ctl));
            check($sformatf("vec%0d_fwd", i), {fwd_a, fwd_b, fwd_s}, tbl[i].fwd);
            @(posedge clk);
            #1;
        end

        // Reset mid-stream: forwarding state must not survive it.
        drive(1'b1, OPR, 5'd1, 5'd1, 5'd20, 1'b1, 1'b0);
        @(negedge clk);
        check("pre_rst_issue0", 6'({stall_id, issue, ex_bubble}), 6'b000010);
        @(posedge clk); #1;
        drive(1'b1, OPR, 5'd20, 5'd20, 5'd21, 1'b1, 1'b0);
        @(negedge clk);
        check("pre_rst_issue1", 6'({stall_id, issue, ex_bubble}), 6'b000010);
        @(posedge clk); #1;
        drive(1'b1, OPR, 5'd21, 5'd20, 5'd22, 1'b1, 1'b0);
        @(negedge clk);
        check("pre_rst_fwd", {fwd_a, fwd_b, fwd_s}, 6'b010100);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_ctl", 6'({stall_id, issue, ex_bubble}), 6'b000000);
        check("rst_async_fwd", {fwd_a, fwd_b, fwd_s}, 6'b000000);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1'b1, OPR, 5'd21, 5'd20, 5'd23, 1'b1, 1'b0);
        @(negedge clk);
        check("post_rst_issue", 6'({stall_id, issue, ex_bubble}), 6'b000010);
        @(posedge clk); #1;
        drive(1'b0, OPX, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        check("post_rst_fwd", {fwd_a, fwd_b, fwd_s}, 6'b000000);
        @(posedge clk); #1;

        // Randomized traffic against the reference model.
        rst_n = 1'b0;
        model_clear();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        for (int n = 0; n < 600; n++) begin
            logic rd1, rd2, wr, ld, st, rdb, haz, e_iss, e_stall, e_bub;
            drive($urandom_range(0, 9) < 8, ops[$urandom_range(0, 5)],
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0);
            rd1 = (id_op == OPR) || (id_op == OPI) || (id_op == OPL) || (id_op == OPS) || (id_op == OPB);
            rd2 = (id_op == OPR) || (id_op == OPS) || (id_op == OPB);
            wr  = (id_op == OPR) || (id_op == OPI) || (id_op == OPL);
            ld  = (id_op == OPL);
            st  = (id_op == OPS);
            rdb = (id_op == OPR) || (id_op == OPB);
            haz = id_valid && !flush && pipe[0].v && pipe[0].ld && pipe[0].wr &&
                  ((rd1 && id_rs1 == pipe[0].rd) || (rd2 && id_rs2 == pipe[0].rd));
            e_iss   = id_valid && ex_ready && !flush && !haz;
            e_stall = (id_valid && !ex_ready) || haz;
            e_bub   = ex_ready && !e_iss;
            @(negedge clk);
            check("rnd_ctl", 6'({stall_id, issue, ex_bubble}), 6'({e_stall, e_iss, e_bub}));
            check("rnd_fwd", {fwd_a, fwd_b, fwd_s}, m_fwd);
            if (ex_ready) begin
                m_fwd = e_iss ? {src(rd1, id_rs1), src(rdb, id_rs2), src(st, id_rs2)} : 6'b000000;
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                if (e_iss) pipe[0] = '{v: 1'b1, wr: wr && (id_rd != 5'd0), ld: ld, rd: id_rd};
                else       pipe[0] = '{v: 1'b0, wr: 1'b0, ld: 1'b0, rd: 5'd0};
            end
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
